// File: rtl/dmem_wait_pkg.sv
// Shared definitions for the wait-state data memory: size codes, FSM states,
// wait-counter width, store payload and the alignment helper.
package dmem_wait_pkg;

    // Wait counter covers 0..15 extra cycles
    localparam int unsigned CNT_W = 4;

    // Access size codes; 2'b11 is reserved and handled as a word
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Store payload: byte-lane enables plus lane-replicated data
    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] data;
    } store_t;

    // Byte accesses are always aligned; half needs bit 0 clear; word needs both clear
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_wait_lane_align.sv
// Byte-lane steering for the data memory (purely combinational).
//   addr_lo      in  2   low address bits selecting the lane
//   size         in  2   access size code
//   sign_ext     in  1   sign-extend sub-word loads when set
//   write_data   in  32  right-justified store data
//   raw_word     in  32  word read from the array
//   store_c      out     byte enables + replicated store word
//   load_data_c  out 32  lane-extracted, extended load value
module dmem_wait_lane_align
    import dmem_wait_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] write_data,
    input  logic [31:0] raw_word,
    output store_t      store_c,
    output logic [31:0] load_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: replicate data over all lanes, then enable only the addressed ones
    always_comb begin
        store_c = '0;
        case (size)
            SZ_BYTE: begin
                store_c.be   = 4'b0001 << addr_lo;
                store_c.data = {4{write_data[7:0]}};
            end
            SZ_HALF: begin
                store_c.be   = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_c.data = {2{write_data[15:0]}};
            end
            default: begin
                store_c.be   = 4'b1111;
                store_c.data = write_data;
            end
        endcase
    end

    // Load side: pick the lane, then sign- or zero-extend
    always_comb begin
        byte_sel    = raw_word[{addr_lo, 3'b000} +: 8];
        half_sel    = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
        load_data_c = raw_word;
        case (size)
            SZ_BYTE: load_data_c = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_c = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data_c = raw_word;
        endcase
    end

endmodule

// File: rtl/dmem_wait.sv
// MEM-stage data memory with configurable wait states and a ready handshake.
//   clk, rst     clock / asynchronous active-high reset
//   addr         byte address, held stable while ready=0
//   writeData    right-justified store data
//   memRead      load request; memWrite store request (store wins if both)
//   size         00 byte, 01 half, 10/11 word
//   signExt      sign-extend sub-word loads
//   readData     registered load result
//   ready        pipeline may advance this cycle
//   misaligned   request violates alignment; access suppressed
module dmem_wait
    import dmem_wait_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       writeData,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [1:0]        size,
    input  logic              signExt,
    output logic [31:0]       readData,
    output logic              ready,
    output logic              misaligned
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam bit          NO_WAIT = (WAIT_CYCLES == 0);

    logic [31:0]      mem [DEPTH];
    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             req;
    logic             aligned;
    logic             go;
    logic             done_entry;
    logic [IDX_W-1:0] idx;
    logic [31:0]      raw_word;
    logic [31:0]      load_data;
    store_t           store;
    logic             unused_addr;

    // Upper address bits wrap silently; fold them into a sink
    assign unused_addr = ^addr;

    assign req      = memRead | memWrite;
    assign aligned  = is_aligned(size, addr[1:0]);
    assign idx      = addr[IDX_W+1:2];
    assign raw_word = mem[idx];

    // An aligned request in IDLE starts an access
    assign go = (state == S_IDLE) && req && aligned;

    // The clock edge that moves the FSM into DONE performs the access
    assign done_entry = ((state == S_WAIT) && (cnt == '0)) || (NO_WAIT && go);

    // Handshake outputs respond in the same cycle as the request
    assign ready      = rst || (state == S_DONE) || ((state == S_IDLE) && !(req && aligned));
    assign misaligned = !rst && (state == S_IDLE) && req && !aligned;

    dmem_wait_lane_align u_lane (
        .addr_lo     (addr[1:0]),
        .size        (size),
        .sign_ext    (signExt),
        .write_data  (writeData),
        .raw_word    (raw_word),
        .store_c     (store),
        .load_data_c (load_data)
    );

    // FSM, wait counter and readData register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            readData <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        if (NO_WAIT) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) state <= S_DONE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            // A store takes priority, so readData only updates on a pure load
            if (done_entry && memRead && !memWrite) readData <= load_data;
        end
    end

    // Array is never cleared; reset suppresses any pending write
    always_ff @(posedge clk) begin
        if (!rst && done_entry && memWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (store.be[i]) mem[idx][8*i +: 8] <= store.data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_wait.sv
// Directed bench for dmem_wait (WAIT_CYCLES=2, DEPTH=64).
module tb_dmem_wait;

    localparam int unsigned WC  = 2;
    localparam int          LAT = WC + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  size;
    logic        signExt;
    logic [31:0] readData;
    logic        ready;
    logic        misaligned;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_wait #(.ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .writeData  (writeData),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .size       (size),
        .signExt    (signExt),
        .readData   (readData),
        .ready      (ready),
        .misaligned (misaligned)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        se;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns cycles until ready and readData at that point
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                          input logic wr, input logic [1:0] sz, input logic se,
                          output int lat, output logic [31:0] rdv);
        addr = a; writeData = wd; memRead = rd; memWrite = wr; size = sz; signExt = se;
        lat = 0;
        #1;
        while (ready !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rdv = readData;
        memRead = 1'b0; memWrite = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] a, input logic [31:0] wd,
                                input logic rd, input logic wr, input logic [1:0] sz,
                                input logic se, input logic [31:0] e);
        vec_t v;
        v.name = n; v.a = a; v.wd = wd; v.rd = rd; v.wr = wr; v.sz = sz; v.se = se; v.exp_rd = e;
        return v;
    endfunction

    initial begin
        int          lat;
        logic [31:0] rdv;

        // Stores expect readData to hold the previous load result
        vecs[0]  = mk("sw_10",      32'h10,  32'hDEADBEEF, 0, 1, 2'b10, 0, 32'h00000000);
        vecs[1]  = mk("lw_10",      32'h10,  32'h0,        1, 0, 2'b10, 0, 32'hDEADBEEF);
        vecs[2]  = mk("sb_11",      32'h11,  32'h000000A5, 0, 1, 2'b00, 0, 32'hDEADBEEF);
        vecs[3]  = mk("lb_11",      32'h11,  32'h0,        1, 0, 2'b00, 1, 32'hFFFFFFA5);
        vecs[4]  = mk("lbu_11",     32'h11,  32'h0,        1, 0, 2'b00, 0, 32'h000000A5);
        vecs[5]  = mk("lw_10_b",    32'h10,  32'h0,        1, 0, 2'b10, 0, 32'hDEADA5EF);
        vecs[6]  = mk("lh_12",      32'h12,  32'h0,        1, 0, 2'b01, 1, 32'hFFFFDEAD);
        vecs[7]  = mk("lhu_12",     32'h12,  32'h0,        1, 0, 2'b01, 0, 32'h0000DEAD);
        vecs[8]  = mk("sh_10",      32'h10,  32'h00008001, 0, 1, 2'b01, 0, 32'h0000DEAD);
        vecs[9]  = mk("lh_10",      32'h10,  32'h0,        1, 0, 2'b01, 1, 32'hFFFF8001);
        vecs[10] = mk("lb_13",      32'h13,  32'h0,        1, 0, 2'b00, 1, 32'hFFFFFFDE);
        vecs[11] = mk("lbu_10",     32'h10,  32'h0,        1, 0, 2'b00, 0, 32'h00000001);
        vecs[12] = mk("sw_100",     32'h100, 32'h12345678, 0, 1, 2'b10, 0, 32'h00000001);
        vecs[13] = mk("lw_0_wrap",  32'h0,   32'h0,        1, 0, 2'b10, 0, 32'h12345678);
        vecs[14] = mk("rdwr_4",     32'h4,   32'hCAFEF00D, 1, 1, 2'b10, 0, 32'h12345678);
        vecs[15] = mk("lw_4",       32'h4,   32'h0,        1, 0, 2'b10, 0, 32'hCAFEF00D);
        vecs[16] = mk("lw_4_rsvd",  32'h4,   32'h0,        1, 0, 2'b11, 0, 32'hCAFEF00D);

        rst = 1'b1; addr = '0; writeData = '0; memRead = 1'b0; memWrite = 1'b0;
        size = 2'b10; signExt = 1'b0;

        // Reset state, including a misaligned request while rst is held
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_misal", 32'(misaligned), 32'd0);
        check("rst_rdata", readData, 32'h0);
        addr = 32'h13; memRead = 1'b1; #1;
        check("rst_req_misal", 32'(misaligned), 32'd0);
        check("rst_req_ready", 32'(ready), 32'd1);
        memRead = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            access(vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].se, lat, rdv);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(LAT));
            check({vecs[i].name, "_rdata"}, rdv, vecs[i].exp_rd);
        end

        // Misaligned load: flagged same cycle, no stall, readData unchanged
        addr = 32'h13; size = 2'b10; memRead = 1'b1; #1;
        check("mis_lw_flag", 32'(misaligned), 32'd1);
        check("mis_lw_ready", 32'(ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("mis_lw_ready_hold", 32'(ready), 32'd1);
        check("mis_lw_rdata", readData, 32'hCAFEF00D);
        memRead = 1'b0;

        // Misaligned word and half stores must not touch memory
        addr = 32'h12; writeData = 32'hFFFFFFFF; size = 2'b10; memWrite = 1'b1; #1;
        check("mis_sw_flag", 32'(misaligned), 32'd1);
        @(posedge clk); #1;
        addr = 32'h11; size = 2'b01; #1;
        check("mis_sh_flag", 32'(misaligned), 32'd1);
        @(posedge clk); #1;
        memWrite = 1'b0;
        addr = 32'h11; size = 2'b00; memRead = 1'b1; #1;
        check("byte_not_misal", 32'(misaligned), 32'd0);
        memRead = 1'b0;
        @(posedge clk); #1;
        access(32'h10, 32'h0, 1, 0, 2'b10, 0, lat, rdv);
        check("mis_mem_unchanged", rdv, 32'hDEAD8001);

        // Reset while idle clears readData
        rst = 1'b1; #1;
        check("idle_rst_rdata", readData, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset during WAIT aborts the store
        access(32'h20, 32'h55AA55AA, 0, 1, 2'b10, 0, lat, rdv);
        access(32'h20, 32'h1, 0, 1, 2'b10, 0, lat, rdv);
        check("prewrite_lat", 32'(lat), 32'(LAT));
        addr = 32'h20; writeData = 32'h00000001; size = 2'b10; memWrite = 1'b1;
        @(posedge clk); #1;
        check("wait_ready_low", 32'(ready), 32'd0);
        rst = 1'b1; #1;
        check("wait_rst_ready", 32'(ready), 32'd1);
        memWrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("wait_rst_rdata", readData, 32'h0);
        access(32'h20, 32'h0, 1, 0, 2'b10, 0, lat, rdv);
        check("abort_lat", 32'(lat), 32'(LAT));
        check("abort_prior", rdv, 32'h00000001);

        // Abort of a store onto different prior contents
        access(32'h24, 32'h0BADF00D, 0, 1, 2'b10, 0, lat, rdv);
        addr = 32'h24; writeData = 32'hFFFFFFFF; size = 2'b10; memWrite = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        memWrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(32'h24, 32'h0, 1, 0, 2'b10, 0, lat, rdv);
        check("abort_late_prior", rdv, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
